// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbitration tree.
package rr_arb_pkg;

  typedef enum logic {
    REQ_GNT = 1'b0,
    VLD_RDY = 1'b1
  } hs_mode_e;

  function automatic int unsigned idx_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/rr_arb_find_first.sv
// Rotated first-one search: lowest set bit at or above start_i, else lowest set bit overall.
module rr_arb_find_first #(
  parameter int unsigned NumIn    = 4,
  parameter int unsigned IdxWidth = 2
) (
  input  logic [NumIn-1:0]    vec_i,
  input  logic [IdxWidth-1:0] start_i,
  output logic [IdxWidth-1:0] idx_o,
  output logic                found_o
);

  localparam int unsigned NumPad = 1 << IdxWidth;

  // Binary tree over the padded vector; the left child wins, so the root holds the lowest set index.
  function automatic logic [IdxWidth:0] lowest(input logic [NumPad-1:0] v);
    logic                vld [2*NumPad-1];
    logic [IdxWidth-1:0] idx [2*NumPad-1];
    for (int unsigned i = 0; i < NumPad; i++) begin
      vld[NumPad-1+i] = v[i];
      idx[NumPad-1+i] = IdxWidth'(i);
    end
    for (int unsigned k = 0; k < NumPad - 1; k++) begin
      int unsigned n;
      n      = NumPad - 2 - k;
      vld[n] = vld[2*n+1] | vld[2*n+2];
      idx[n] = vld[2*n+1] ? idx[2*n+1] : idx[2*n+2];
    end
    return {vld[0], idx[0]};
  endfunction

  logic [NumPad-1:0]   raw_vec;
  logic [NumPad-1:0]   masked_vec;
  logic [IdxWidth:0]   hit_masked;
  logic [IdxWidth:0]   hit_raw;

  always_comb begin
    raw_vec    = '0;
    masked_vec = '0;
    for (int unsigned i = 0; i < NumIn; i++) begin
      raw_vec[i]    = vec_i[i];
      masked_vec[i] = vec_i[i] & (IdxWidth'(i) >= start_i);
    end
    hit_masked = lowest(masked_vec);
    hit_raw    = lowest(raw_vec);
    found_o    = hit_raw[IdxWidth];
    idx_o      = hit_masked[IdxWidth] ? hit_masked[IdxWidth-1:0] : hit_raw[IdxWidth-1:0];
  end

endmodule

// File: rtl/rr_arb_tree_lock.sv
// Round-robin arbiter with optional external pointer, fair/incrementing pointer update and stall lock-in.
module rr_arb_tree_lock
  import rr_arb_pkg::*;
#(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned DataWidth = 32,
  parameter bit          ExtPrio   = 1'b0,
  parameter bit          FairArb   = 1'b1,
  parameter bit          LockIn    = 1'b1,
  parameter bit          AxiVldRdy = 1'b0,
  parameter int unsigned IdxWidth  = idx_width(NumReq)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic [IdxWidth-1:0]         rr_i,
  input  logic [NumReq-1:0]           req_i,
  output logic [NumReq-1:0]           gnt_o,
  input  logic [NumReq*DataWidth-1:0] data_i,
  output logic                        req_o,
  input  logic                        gnt_i,
  output logic [DataWidth-1:0]        data_o,
  output logic [IdxWidth-1:0]         idx_o
);

  localparam hs_mode_e HsMode = hs_mode_e'(AxiVldRdy);

  if (NumReq == 1) begin : g_single
    logic unused_inputs;
    assign unused_inputs = ^{clk_i, rst_ni, flush_i, rr_i};
    assign req_o  = req_i[0];
    assign data_o = data_i;
    assign idx_o  = '0;
    assign gnt_o  = gnt_i & req_i;
  end else begin : g_tree
    logic [IdxWidth-1:0] rr_q, idx_q, ptr, start, ff_idx, win_idx;
    logic                lock_q, ff_found, lock_hold, hs;

    // Out-of-range external pointers saturate to the last requester.
    assign ptr = ExtPrio ? ((32'(rr_i) >= NumReq) ? IdxWidth'(NumReq - 1) : rr_i) : rr_q;
    assign start = (32'(ptr) == NumReq - 1) ? '0 : ptr + 1'b1;

    rr_arb_find_first #(
      .NumIn    (NumReq),
      .IdxWidth (IdxWidth)
    ) u_find_first (
      .vec_i   (req_i),
      .start_i (start),
      .idx_o   (ff_idx),
      .found_o (ff_found)
    );

    // A dropped locked request falls back to normal arbitration.
    assign lock_hold = LockIn && lock_q && req_i[idx_q];
    assign win_idx   = lock_hold ? idx_q : ff_idx;
    assign req_o     = ff_found;
    assign idx_o     = req_o ? win_idx : '0;
    assign hs        = req_o & gnt_i;

    always_comb begin
      gnt_o  = '0;
      data_o = '0;
      for (int unsigned i = 0; i < NumReq; i++) begin
        if (req_o && (win_idx == IdxWidth'(i))) begin
          gnt_o[i] = gnt_i;
          data_o   = data_i[i*DataWidth +: DataWidth];
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rr_q   <= IdxWidth'(NumReq - 1);
        lock_q <= 1'b0;
        idx_q  <= '0;
      end else if (flush_i) begin
        rr_q   <= IdxWidth'(NumReq - 1);
        lock_q <= 1'b0;
        idx_q  <= '0;
      end else begin
        if (hs) begin
          if (FairArb) rr_q <= idx_o;
          else         rr_q <= (32'(rr_q) == NumReq - 1) ? '0 : rr_q + 1'b1;
        end
        if (LockIn) begin
          if (req_o && !gnt_i) begin
            lock_q <= 1'b1;
            idx_q  <= idx_o;
          end else begin
            lock_q <= 1'b0;
          end
        end
      end
    end

    a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));
    a_req_known:   assert property (@(posedge clk_i) disable iff (!rst_ni) !$isunknown(req_o));
    a_lock_held:   assert property (@(posedge clk_i) disable iff (!rst_ni) lock_q |-> req_i[idx_q])
      else $error("locked requester %0d dropped its %s", idx_q, (HsMode == VLD_RDY) ? "valid" : "request");
    a_lock_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    (lock_q && req_i[idx_q]) |-> (idx_o == idx_q));
  end

endmodule

// File: tb/tb_rr_arb_tree_lock.sv
// Self-checking bench: vector tables for three arbiter configurations plus a randomized valid/ready stream.
module tb_rr_arb_tree_lock;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  // fair: NumReq=4 FairArb=1 LockIn=1
  logic         f_flush, f_gnt, f_req_o;
  logic [1:0]   f_rr, f_idx_o;
  logic [3:0]   f_req, f_gnt_o;
  logic [127:0] f_data;
  logic [31:0]  f_data_o;
  // rot: NumReq=4 FairArb=0
  logic         r_flush, r_gnt, r_req_o;
  logic [1:0]   r_rr, r_idx_o;
  logic [3:0]   r_req, r_gnt_o;
  logic [127:0] r_data;
  logic [31:0]  r_data_o;
  // ext: NumReq=5 ExtPrio=1
  logic         e_flush, e_gnt, e_req_o;
  logic [2:0]   e_rr, e_idx_o;
  logic [4:0]   e_req, e_gnt_o;
  logic [159:0] e_data;
  logic [31:0]  e_data_o;
  // axi: NumReq=5 AxiVldRdy=1
  logic         a_flush, a_gnt, a_req_o;
  logic [2:0]   a_rr, a_idx_o;
  logic [4:0]   a_vld, a_gnt_o;
  logic [159:0] a_data;
  logic [31:0]  a_data_o;

  rr_arb_tree_lock #(.NumReq(4), .DataWidth(32), .ExtPrio(1'b0), .FairArb(1'b1), .LockIn(1'b1), .AxiVldRdy(1'b0))
  u_fair (.clk_i(clk), .rst_ni(rst_ni), .flush_i(f_flush), .rr_i(f_rr), .req_i(f_req), .gnt_o(f_gnt_o),
          .data_i(f_data), .req_o(f_req_o), .gnt_i(f_gnt), .data_o(f_data_o), .idx_o(f_idx_o));

  rr_arb_tree_lock #(.NumReq(4), .DataWidth(32), .ExtPrio(1'b0), .FairArb(1'b0), .LockIn(1'b1), .AxiVldRdy(1'b0))
  u_rot (.clk_i(clk), .rst_ni(rst_ni), .flush_i(r_flush), .rr_i(r_rr), .req_i(r_req), .gnt_o(r_gnt_o),
         .data_i(r_data), .req_o(r_req_o), .gnt_i(r_gnt), .data_o(r_data_o), .idx_o(r_idx_o));

  rr_arb_tree_lock #(.NumReq(5), .DataWidth(32), .ExtPrio(1'b1), .FairArb(1'b1), .LockIn(1'b1), .AxiVldRdy(1'b0))
  u_ext (.clk_i(clk), .rst_ni(rst_ni), .flush_i(e_flush), .rr_i(e_rr), .req_i(e_req), .gnt_o(e_gnt_o),
         .data_i(e_data), .req_o(e_req_o), .gnt_i(e_gnt), .data_o(e_data_o), .idx_o(e_idx_o));

  rr_arb_tree_lock #(.NumReq(5), .DataWidth(32), .ExtPrio(1'b0), .FairArb(1'b1), .LockIn(1'b1), .AxiVldRdy(1'b1))
  u_axi (.clk_i(clk), .rst_ni(rst_ni), .flush_i(a_flush), .rr_i(a_rr), .req_i(a_vld), .gnt_o(a_gnt_o),
         .data_i(a_data), .req_o(a_req_o), .gnt_i(a_gnt), .data_o(a_data_o), .idx_o(a_idx_o));

  typedef struct {
    int unsigned dut;
    logic [4:0]  req;
    logic        gnt;
    logic        flush;
    logic [2:0]  rr;
    logic [2:0]  exp_idx;
    logic [4:0]  exp_gnt;
  } vec_t;

  typedef struct {
    int unsigned dut;
    int unsigned vec;
    logic        req_o;
    logic [2:0]  idx;
    logic [4:0]  gnt;
    logic [31:0] data;
  } exp_t;

  vec_t        tab[$];
  exp_t        exp_q[$];
  logic [31:0] sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  function automatic vec_t mk(int unsigned dut, logic [4:0] req, logic gnt, logic flush, logic [2:0] rr,
                              logic [2:0] idx, logic [4:0] g);
    vec_t v;
    v.dut = dut; v.req = req; v.gnt = gnt; v.flush = flush; v.rr = rr; v.exp_idx = idx; v.exp_gnt = g;
    return v;
  endfunction

  function automatic logic [31:0] base_of(int unsigned dut);
    case (dut)
      0:       return 32'hF000_0000;
      1:       return 32'hB000_0000;
      default: return 32'hE000_0000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    case (v.dut)
      0:       begin f_req = v.req[3:0]; f_gnt = v.gnt; f_flush = v.flush; end
      1:       begin r_req = v.req[3:0]; r_gnt = v.gnt; r_flush = v.flush; end
      default: begin e_req = v.req; e_gnt = v.gnt; e_flush = v.flush; e_rr = v.rr; end
    endcase
  endtask

  task automatic compare(input exp_t e);
    logic        a_r;
    logic [2:0]  a_i;
    logic [4:0]  a_g;
    logic [31:0] a_d;
    case (e.dut)
      0:       begin a_r = f_req_o; a_i = {1'b0, f_idx_o}; a_g = {1'b0, f_gnt_o}; a_d = f_data_o; end
      1:       begin a_r = r_req_o; a_i = {1'b0, r_idx_o}; a_g = {1'b0, r_gnt_o}; a_d = r_data_o; end
      default: begin a_r = e_req_o; a_i = e_idx_o;         a_g = e_gnt_o;         a_d = e_data_o; end
    endcase
    check($sformatf("dut%0d vec%0d req_o", e.dut, e.vec), 32'(a_r), 32'(e.req_o));
    check($sformatf("dut%0d vec%0d idx_o", e.dut, e.vec), 32'(a_i), 32'(e.idx));
    check($sformatf("dut%0d vec%0d gnt_o", e.dut, e.vec), 32'(a_g), 32'(e.gnt));
    check($sformatf("dut%0d vec%0d data_o", e.dut, e.vec), a_d, e.data);
  endtask

  initial begin
    exp_t        e;
    int unsigned wait_cnt [5];
    int unsigned seq [5];
    int          acc;

    rst_ni = 1'b0;
    {f_flush, f_gnt, f_rr, f_req} = '0;
    {r_flush, r_gnt, r_rr, r_req} = '0;
    {e_flush, e_gnt, e_rr, e_req} = '0;
    {a_flush, a_gnt, a_rr, a_vld} = '0;
    a_data = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      f_data[i*32 +: 32] = base_of(0) + i;
      r_data[i*32 +: 32] = base_of(1) + i;
    end
    for (int unsigned i = 0; i < 5; i++) e_data[i*32 +: 32] = base_of(2) + i;
    for (int unsigned i = 0; i < 5; i++) begin wait_cnt[i] = 0; seq[i] = 0; end

    // fair round robin, pointer starts at NumReq-1
    tab.push_back(mk(0, 5'b00000, 1, 0, 0, 0, 5'b00000));
    tab.push_back(mk(0, 5'b01111, 1, 0, 0, 0, 5'b00001));
    tab.push_back(mk(0, 5'b01111, 1, 0, 0, 1, 5'b00010));
    tab.push_back(mk(0, 5'b01111, 1, 0, 0, 2, 5'b00100));
    tab.push_back(mk(0, 5'b01111, 1, 0, 0, 3, 5'b01000));
    tab.push_back(mk(0, 5'b01111, 1, 0, 0, 0, 5'b00001));
    tab.push_back(mk(0, 5'b01100, 1, 0, 0, 2, 5'b00100));
    tab.push_back(mk(0, 5'b01100, 1, 0, 0, 3, 5'b01000));
    tab.push_back(mk(0, 5'b01100, 1, 0, 0, 2, 5'b00100));
    tab.push_back(mk(0, 5'b01100, 1, 0, 0, 3, 5'b01000));
    // lock-in while stalled, then release
    tab.push_back(mk(0, 5'b00010, 0, 0, 0, 1, 5'b00000));
    tab.push_back(mk(0, 5'b00011, 0, 0, 0, 1, 5'b00000));
    tab.push_back(mk(0, 5'b00011, 0, 0, 0, 1, 5'b00000));
    tab.push_back(mk(0, 5'b00011, 1, 0, 0, 1, 5'b00010));
    tab.push_back(mk(0, 5'b00011, 1, 0, 0, 0, 5'b00001));
    // flush: pre-flush state drives outputs, then pointer and lock return to reset values
    tab.push_back(mk(0, 5'b01111, 1, 0, 0, 1, 5'b00010));
    tab.push_back(mk(0, 5'b01111, 1, 0, 0, 2, 5'b00100));
    tab.push_back(mk(0, 5'b00110, 1, 1, 0, 1, 5'b00010));
    tab.push_back(mk(0, 5'b01111, 1, 0, 0, 0, 5'b00001));
    tab.push_back(mk(0, 5'b00100, 0, 1, 0, 2, 5'b00000));
    tab.push_back(mk(0, 5'b01111, 1, 0, 0, 0, 5'b00001));
    tab.push_back(mk(0, 5'b00000, 1, 0, 0, 0, 5'b00000));
    tab.push_back(mk(0, 5'b01000, 1, 0, 0, 3, 5'b01000));
    // incrementing pointer
    tab.push_back(mk(1, 5'b00000, 1, 0, 0, 0, 5'b00000));
    tab.push_back(mk(1, 5'b01100, 1, 0, 0, 2, 5'b00100));
    tab.push_back(mk(1, 5'b01100, 1, 0, 0, 2, 5'b00100));
    tab.push_back(mk(1, 5'b01100, 1, 0, 0, 2, 5'b00100));
    tab.push_back(mk(1, 5'b01100, 1, 0, 0, 3, 5'b01000));
    tab.push_back(mk(1, 5'b01100, 1, 0, 0, 2, 5'b00100));
    // external pointer, including out-of-range values
    tab.push_back(mk(2, 5'b00000, 1, 0, 0, 0, 5'b00000));
    tab.push_back(mk(2, 5'b01111, 1, 0, 2, 3, 5'b01000));
    tab.push_back(mk(2, 5'b11111, 1, 0, 7, 0, 5'b00001));
    tab.push_back(mk(2, 5'b11111, 1, 0, 4, 0, 5'b00001));
    tab.push_back(mk(2, 5'b10000, 1, 0, 0, 4, 5'b10000));
    tab.push_back(mk(2, 5'b00101, 1, 0, 3, 0, 5'b00001));
    tab.push_back(mk(2, 5'b00110, 1, 0, 5, 1, 5'b00010));
    tab.push_back(mk(2, 5'b00100, 1, 0, 1, 2, 5'b00100));
    tab.push_back(mk(2, 5'b01000, 1, 0, 6, 3, 5'b01000));

    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    @(posedge clk); #1;

    foreach (tab[k]) begin
      drive(tab[k]);
      e.dut   = tab[k].dut;
      e.vec   = k;
      e.req_o = |tab[k].req;
      e.idx   = tab[k].exp_idx;
      e.gnt   = tab[k].exp_gnt;
      e.data  = e.req_o ? base_of(tab[k].dut) + 32'(tab[k].exp_idx) : '0;
      exp_q.push_back(e);
      @(negedge clk);
      compare(exp_q.pop_front());
      @(posedge clk); #1;
    end
    f_flush = 1'b0; r_flush = 1'b0; e_flush = 1'b0;

    // Asynchronous reset while a stalled decision is locked must forget the lock at once.
    f_req = 4'b0010; f_gnt = 1'b0;
    @(negedge clk);
    check("rst_seq stall idx_o", 32'(f_idx_o), 32'd1);
    check("rst_seq stall gnt_o", 32'(f_gnt_o), 32'd0);
    @(posedge clk);
    #2 rst_ni = 1'b0;
    #1 f_req = 4'b0011; f_gnt = 1'b1;
    #1;
    check("rst_seq in-reset idx_o", 32'(f_idx_o), 32'd0);
    check("rst_seq in-reset gnt_o", 32'(f_gnt_o), 32'b0001);
    rst_ni = 1'b1;
    @(negedge clk);
    check("rst_seq post idx_o", 32'(f_idx_o), 32'd0);
    check("rst_seq post data_o", f_data_o, base_of(0));
    @(posedge clk); #1;
    f_req = '0;

    // Valid/ready stream with held payloads; each beat's payload is tagged with its source.
    for (int unsigned cyc = 0; cyc < 10000; cyc++) begin
      for (int unsigned i = 0; i < 5; i++) begin
        if (!a_vld[i] && ($urandom_range(0, 2) != 0)) begin
          a_vld[i]           = 1'b1;
          a_data[i*32 +: 32] = {8'(i), 24'(seq[i])};
          sb_q.push_back({8'(i), 24'(seq[i])});
          seq[i]++;
          wait_cnt[i] = 0;
        end
      end
      a_gnt = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("axi req_o", 32'(a_req_o), 32'(|a_vld));
      check("axi grant count", 32'($countones(a_gnt_o)), 32'(a_gnt && (|a_vld)));
      acc = -1;
      if (a_req_o && a_gnt) begin
        acc = int'(a_idx_o);
        if (acc >= 5 || !a_vld[acc]) begin
          check("axi winner valid", 32'(acc), 32'hFFFF_FFFF);
          acc = -1;
        end else begin
          int found;
          found = -1;
          foreach (sb_q[j]) if (found < 0 && sb_q[j][31:24] == 8'(acc)) found = j;
          if (found < 0) begin
            check("axi scoreboard hit", 32'(acc), 32'hFFFF_FFFF);
          end else begin
            check("axi beat payload", a_data_o, sb_q[found]);
            sb_q.delete(found);
          end
          check("axi starvation bound", 32'(wait_cnt[acc] <= 5), 32'd1);
          for (int unsigned i = 0; i < 5; i++) if (a_vld[i] && int'(i) != acc) wait_cnt[i]++;
        end
      end
      @(posedge clk); #1;
      if (acc >= 0) a_vld[acc] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
